// File: rtl/mul_p3.sv
// mul_p3 -- third stage of the single-precision multiplier pipeline.
// Normalizes the 48-bit mantissa product and rounds it. Detects exponent
// overflow and underflow, then registers the packed result behind a
// valid/ready handshake with one output register.
// Build option: define MUL_P3_RNE_EN for round-to-nearest-even.
// Without it, the fraction is truncated.
// Reset rst is asynchronous and active-high.
module mul_p3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [9:0]  exp_in,
    input  logic [47:0] prod_in,
    input  logic        zero_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_out,
    output logic [8:0]  exp_out,
    output logic [22:0] mant_out,
    output logic        ovf,
    output logic        unf
);

`ifdef MUL_P3_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    logic [22:0]        frac;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic [23:0]        frac_sum;
    logic signed [10:0] e_norm;
    logic signed [10:0] e_fin;
    logic [8:0]         exp_next;
    logic [22:0]        mant_next;
    logic               ovf_next;
    logic               unf_next;

    // The stage can take a new input when the output register is empty or draining.
    assign in_ready = !out_valid | out_ready;

    // Normalize, round, then classify the exponent into normal, overflow, underflow or zero.
    always_comb begin
        frac      = prod_in[45:23];
        guard     = prod_in[22];
        sticky    = |prod_in[21:0];
        e_norm    = $signed({exp_in[9], exp_in});
        exp_next  = 9'd0;
        mant_next = 23'd0;
        ovf_next  = 1'b0;
        unf_next  = 1'b0;

        if (prod_in[47]) begin
            frac   = prod_in[46:24];
            guard  = prod_in[23];
            sticky = |prod_in[22:0];
            e_norm = $signed({exp_in[9], exp_in}) + 11'sd1;
        end

        // Keep guard and sticky live in both builds; the constant RNE folds the truncating case away.
        round_up = RNE & guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {23'd0, round_up};
        // A carry out of the fraction means 1.111.. rounded to 10.000..; the fraction is already zero.
        e_fin    = e_norm + $signed({10'd0, frac_sum[23]});

        if (zero_in) begin
            exp_next  = 9'd0;
            mant_next = 23'd0;
        end else if (e_fin >= 11'sd255) begin
            exp_next = 9'h0FF;
            ovf_next = 1'b1;
        end else if (e_fin <= 11'sd0) begin
            unf_next = 1'b1;
        end else begin
            exp_next  = e_fin[8:0];
            mant_next = frac_sum[22:0];
        end
    end

    // Output register: load on input transfer, clear valid when drained with no new input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            exp_out   <= 9'd0;
            mant_out  <= 23'd0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                sign_out <= sign_in;
                exp_out  <= exp_next;
                mant_out <= mant_next;
                ovf      <= ovf_next;
                unf      <= unf_next;
            end
        end
    end

endmodule

// File: tb/tb_mul_p3.sv
// Self-checking bench for mul_p3.
// An independent model predicts each result when the input is accepted and
// pushes it to a scoreboard queue. The queue head is compared with the DUT
// outputs every cycle the register should hold data.
// Honours MUL_P3_RNE_EN in the same way the design does.
module tb_mul_p3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [47:0] prod_in;
    logic        zero_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [8:0]  exp_out;
    logic [22:0] mant_out;
    logic        ovf;
    logic        unf;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected result packed as {sign, exp[8:0], mant[22:0], ovf, unf}.
    logic [34:0] sb_q[$];

    mul_p3 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .prod_in(prod_in), .zero_in(zero_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model. Rounding uses the remainder against the halfway point.
    function automatic logic [34:0] model(input logic s, input logic [9:0] ei,
                                          input logic [47:0] p, input logic z);
        int          e;
        int          sh;
        logic [47:0] one;
        logic [47:0] mask;
        logic [47:0] rem;
        logic [47:0] half;
        logic [47:0] q;
        logic [22:0] f;
        logic        up;
        if (z) return {s, 9'd0, 23'd0, 1'b0, 1'b0};
        e   = int'($signed(ei));
        sh  = p[47] ? 24 : 23;
        if (p[47]) e = e + 1;
        one  = 48'd1;
        mask = (one << sh) - one;
        half = one << (sh - 1);
        rem  = p & mask;
        q    = p >> sh;
        f    = q[22:0];
`ifdef MUL_P3_RNE_EN
        up = (rem > half) || ((rem == half) && f[0]);
`else
        up = 1'b0;
`endif
        if (up) begin
            if (f == 23'h7FFFFF) begin
                f = 23'd0;
                e = e + 1;
            end else begin
                f = f + 23'd1;
            end
        end
        if (e >= 255) return {s, 9'h0FF, 23'd0, 1'b1, 1'b0};
        if (e <= 0)   return {s, 9'd0, 23'd0, 1'b0, 1'b1};
        return {s, 9'(e), f, 1'b0, 1'b0};
    endfunction

    // One clock cycle. Inputs are already driven after a negedge.
    // Check outputs, then account for the transfers at the posedge.
    task automatic step(input string tag);
        logic       acc;
        logic       ret;
        logic [34:0] hd;
        #1;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(sb_q.size() > 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'((sb_q.size() == 0) || out_ready));
        if (sb_q.size() > 0) begin
            hd = sb_q[0];
            chk({tag, ".sign"}, 64'(sign_out), 64'(hd[34]));
            chk({tag, ".exp"},  64'(exp_out),  64'(hd[33:25]));
            chk({tag, ".mant"}, 64'(mant_out), 64'(hd[24:2]));
            chk({tag, ".ovf"},  64'(ovf),      64'(hd[1]));
            chk({tag, ".unf"},  64'(unf),      64'(hd[0]));
            $display("%s: out s=%0d e=0x%0h m=0x%0h ovf=%0d unf=%0d rdy=%0d",
                     tag, sign_out, exp_out, mant_out, ovf, unf, out_ready);
        end
        acc = in_valid && (sb_q.size() == 0 || out_ready);
        ret = (sb_q.size() > 0) && out_ready;
        @(posedge clk);
        if (ret) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(model(sign_in, exp_in, prod_in, zero_in));
        @(negedge clk);
    endtask

    task automatic drive(input string tag, input logic v, input logic s, input logic [9:0] e,
                         input logic [47:0] p, input logic z, input logic r);
        in_valid  = v;
        sign_in   = s;
        exp_in    = e;
        prod_in   = p;
        zero_in   = z;
        out_ready = r;
        step(tag);
    endtask

    initial begin
        int          er;
        logic [47:0] pr;
        rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = 10'd0;
        prod_in = 48'd0; zero_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.data", 64'({sign_out, exp_out, mant_out, ovf, unf}), 64'd0);
        rst = 1'b0;

        // Directed vectors, back to back.
        drive("mul_1p5sq",  1, 0, 10'd127, 48'h900000000000, 0, 1);
        drive("round_carry", 1, 0, 10'd100, 48'h7FFFFFC00000, 0, 1);
        drive("no_guard",   1, 0, 10'd100, 48'h7FFFFF800000, 0, 1);
        drive("tie_even",   1, 1, 10'd50,  48'h400000400000, 0, 1);
        drive("tie_odd",    1, 0, 10'd50,  48'h400000C00000, 0, 1);
        drive("overflow",   1, 0, 10'd254, 48'h800000000000, 0, 1);
        drive("underflow",  1, 1, 10'd0,   48'h400000000000, 0, 1);
        drive("neg_exp",    1, 0, 10'h381, 48'hC00000000000, 0, 1);
        drive("max_norm",   1, 0, 10'd254, 48'h7FFFFF000000, 0, 1);
        drive("zero_ovr",   1, 1, 10'd300, 48'h000000000000, 1, 1);
        drive("idle",       0, 0, 10'd0,   48'd0, 0, 1);
        drive("idle2",      0, 0, 10'd0,   48'd0, 0, 1);

        // Stall for three cycles while holding a result, then transfer both ways at once.
        drive("stall_load", 1, 0, 10'd127, 48'h900000000000, 0, 1);
        drive("stall1",     1, 1, 10'd10,  48'h400000000001, 0, 0);
        drive("stall2",     1, 1, 10'd10,  48'h400000000001, 0, 0);
        drive("stall3",     1, 1, 10'd10,  48'h400000000001, 0, 0);
        drive("swap",       1, 1, 10'd10,  48'h400000000001, 0, 1);
        drive("drain",      0, 0, 10'd0,   48'd0, 0, 1);
        drive("empty",      0, 0, 10'd0,   48'd0, 0, 1);

        // Reset pulsed mid-stall must clear everything before the next edge.
        drive("pre_rst",    1, 1, 10'd200, 48'hFFFFFFFFFFFF, 0, 1);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.in_ready",  64'(in_ready),  64'd1);
        chk("midrst.data", 64'({sign_out, exp_out, mant_out, ovf, unf}), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive("post_rst",   1, 0, 10'd127, 48'h900000000000, 0, 1);
        drive("post_rst2",  0, 0, 10'd0,   48'd0, 0, 1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            er = int'($urandom_range(0, 510)) - 127;
            pr = {$urandom, $urandom};
            pr[47:46] = 2'($urandom_range(1, 3));
            drive("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  10'(er), pr, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
        end
        drive("flush", 0, 0, 10'd0, 48'd0, 0, 1);
        drive("flush2", 0, 0, 10'd0, 48'd0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
